gshare_predictor: RTL

Parametrised next-generation fetch-stage direction/target predictor for the fetch1 front end. Each lookup predicts a FETCH_W-wide instruction group. Direction comes from a gshare PHT of 2-bit counters, indexed by PC XOR global history. Targets come from a tagged, valid-bit BTB. Adds, relative to the current fetch predictor: speculative GHR with mispredict repair, explicit not-a-branch invalidation, and a reset-time table-clearing sweep.

---
 rtl/gshare_predictor_pkg.sv | 18 +
 rtl/gshare_predictor_sat_counter2.sv | 19 +
 rtl/gshare_predictor.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/gshare_predictor_pkg.sv
// Shared types and constants for the gshare direction/target predictor.
package gshare_predictor_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [1:0] CNT_SNT = 2'b00;
    localparam logic [1:0] CNT_WNT = 2'b01;
    localparam logic [1:0] CNT_WT  = 2'b10;
    localparam logic [1:0] CNT_ST  = 2'b11;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/gshare_predictor_sat_counter2.sv
// 2-bit saturating counter next-value logic; holds at SNT and ST instead of wrapping.
module sat_counter2
    import gshare_predictor_pkg::*;
(
    input  logic [1:0] count,
    input  logic       taken,
    output logic [1:0] next_count
);

    always_comb begin
        next_count = count;
        if (taken) begin
            if (count != CNT_ST) next_count = count + 2'd1;
        end else begin
            if (count != CNT_SNT) next_count = count - 2'd1;
        end
    end

endmodule

// File: rtl/gshare_predictor.sv
// Fetch-group direction/target predictor: gshare PHT of 2-bit counters plus tagged BTB,
// speculative GHR with mispredict repair, and a post-reset table-clearing sweep.
//
// state | meaning
// INIT  | sweeping tables one entry per cycle; lookups and updates ignored
// RUN   | lookups valid, training and GHR tracking active
module gshare_predictor
    import gshare_predictor_pkg::*;
#(
    parameter int FETCH_W   = 2,
    parameter int PHT_ABITS = 10,
    parameter int BTB_ABITS = 8,
    parameter int GHR_W     = 8,
    parameter int GSHARE    = 1
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  we_i,
    input  logic [31:0]           pc_i,
    output logic                  ready_o,
    output logic [FETCH_W-1:0]    pred_o,
    output logic [32*FETCH_W-1:0] pred_tgt_o,
    output logic [GHR_W-1:0]      ghr_o,
    input  logic                  upd_valid_i,
    input  logic                  upd_is_br_i,
    input  logic [31:0]           upd_pc_i,
    input  logic                  upd_taken_i,
    input  logic [31:0]           upd_tgt_i,
    input  logic [GHR_W-1:0]      upd_ghr_i,
    input  logic                  mispredict_i
);

    localparam int SWEEP_ABITS = max_int(PHT_ABITS, BTB_ABITS);
    localparam int PHT_DEPTH   = 1 << PHT_ABITS;
    localparam int BTB_DEPTH   = 1 << BTB_ABITS;
    localparam int TAG_W       = 30 - BTB_ABITS;
    localparam logic [SWEEP_ABITS-1:0] SWEEP_LAST = '1;

    state_t                 state, state_nxt;
    logic [SWEEP_ABITS-1:0] sweep;
    logic [31:0]            pc_q;
    logic [GHR_W-1:0]       ghr;
    logic                   ready;

    logic [1:0]             pht       [PHT_DEPTH];
    logic [BTB_DEPTH-1:0]   btb_valid;
    logic [TAG_W-1:0]       btb_tag   [BTB_DEPTH];
    logic [31:0]            btb_tgt   [BTB_DEPTH];

    logic [FETCH_W-1:0]     hit;
    logic [FETCH_W-1:0]     raw;
    logic                   pht_in_range;
    logic                   btb_in_range;

    function automatic logic [PHT_ABITS-1:0] pht_index(input logic [PHT_ABITS-1:0] word_idx,
                                                       input logic [GHR_W-1:0]     hist);
        logic [PHT_ABITS-1:0] idx;
        idx = word_idx;
        if (GSHARE != 0) idx = idx ^ PHT_ABITS'(hist);
        return idx;
    endfunction

    function automatic logic [GHR_W-1:0] ghr_shift(input logic [GHR_W-1:0] hist,
                                                   input logic             bit_in);
        logic [GHR_W:0] ext;
        ext = {hist, bit_in};
        return ext[GHR_W-1:0];
    endfunction

    always_ff @(posedge clock_i) begin
        if (reset_i) state <= ST_INIT;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT: if (sweep == SWEEP_LAST) state_nxt = ST_RUN;
            ST_RUN:  state_nxt = ST_RUN;
            default: state_nxt = ST_INIT;
        endcase
    end

    assign ready = (state == ST_RUN);

    always_ff @(posedge clock_i) begin
        if (reset_i)               sweep <= '0;
        else if (state == ST_INIT) sweep <= sweep + SWEEP_ABITS'(1);
    end

    // The smaller table skips sweep indices beyond its own depth.
    if (SWEEP_ABITS > PHT_ABITS) begin : g_pht_rng
        assign pht_in_range = (sweep[SWEEP_ABITS-1:PHT_ABITS] == '0);
    end else begin : g_pht_all
        assign pht_in_range = 1'b1;
    end

    if (SWEEP_ABITS > BTB_ABITS) begin : g_btb_rng
        assign btb_in_range = (sweep[SWEEP_ABITS-1:BTB_ABITS] == '0);
    end else begin : g_btb_all
        assign btb_in_range = 1'b1;
    end

    for (genvar k = 0; k < FETCH_W; k++) begin : g_slot
        logic [29:0]          pc_w;
        logic [BTB_ABITS-1:0] bidx;
        logic [PHT_ABITS-1:0] pidx;
        assign pc_w   = pc_q[31:2] + 30'(k);
        assign bidx   = pc_w[BTB_ABITS-1:0];
        assign pidx   = pht_index(pc_w[PHT_ABITS-1:0], ghr);
        assign hit[k] = btb_valid[bidx] && (btb_tag[bidx] == pc_w[29:BTB_ABITS]);
        assign raw[k] = hit[k] && pht[pidx][1];
        assign pred_tgt_o[32*k +: 32] = (ready && hit[k]) ? btb_tgt[bidx] : 32'h0;
    end

    assign pred_o  = ready ? (raw & (~raw + FETCH_W'(1))) : '0;
    assign ready_o = ready;
    assign ghr_o   = ghr;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            ghr  <= '0;
            pc_q <= '0;
        end else if (state == ST_RUN) begin
            if (mispredict_i)            ghr <= ghr_shift(upd_ghr_i, upd_taken_i);
            else if (we_i && (|pred_o))  ghr <= ghr_shift(ghr, 1'b1);
            else if (we_i && (|hit))     ghr <= ghr_shift(ghr, 1'b0);
            if (we_i) pc_q <= pc_i;
        end
    end

    logic [PHT_ABITS-1:0] upd_pidx;
    logic [BTB_ABITS-1:0] upd_bidx;
    logic [TAG_W-1:0]     upd_tag;
    logic [1:0]           upd_cnt_nxt;
    logic                 unused_bits;

    assign upd_pidx    = pht_index(upd_pc_i[PHT_ABITS+1:2], upd_ghr_i);
    assign upd_bidx    = upd_pc_i[BTB_ABITS+1:2];
    assign upd_tag     = upd_pc_i[31:BTB_ABITS+2];
    assign unused_bits = ^{upd_pc_i[1:0], pc_q[1:0]};

    sat_counter2 u_sat (
        .count      (pht[upd_pidx]),
        .taken      (upd_taken_i),
        .next_count (upd_cnt_nxt)
    );

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            if (state == ST_INIT) begin
                if (pht_in_range) pht[sweep[PHT_ABITS-1:0]]       <= CNT_WNT;
                if (btb_in_range) btb_valid[sweep[BTB_ABITS-1:0]] <= 1'b0;
            end else if (upd_valid_i) begin
                if (upd_is_br_i) begin
                    pht[upd_pidx] <= upd_cnt_nxt;
                    if (upd_taken_i) begin
                        btb_valid[upd_bidx] <= 1'b1;
                        btb_tag[upd_bidx]   <= upd_tag;
                        btb_tgt[upd_bidx]   <= upd_tgt_i;
                    end
                end else if (btb_tag[upd_bidx] == upd_tag) begin
                    btb_valid[upd_bidx] <= 1'b0;
                end
            end
        end
    end

endmodule
